// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 command codes, transmitter state encoding and parity helper.
package ps2_host_tx_pkg;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;

    typedef enum logic [2:0] {
        PS2TX_IDLE,
        PS2TX_INHIBIT,
        PS2TX_REQ,
        PS2TX_SHIFT,
        PS2TX_ACK,
        PS2TX_WAITHI
    } ps2tx_state_e;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: 3-flop synchroniser for a raw PS/2 line, giving a settled level and a fall pulse.
module ps2_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);
    logic [2:0] s_q;
    logic [2:0] s_d;

    always_comb s_d = {s_q[1:0], din};

    // Resets to the idle-high bus level so leaving reset never looks like a fall.
    always_ff @(posedge clk) begin
        if (rst) s_q <= 3'b111;
        else     s_q <= s_d;
    end

    assign level = s_q[1];
    assign fall  = s_q[2] & ~s_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, shift, line ACK).
// Optional device-clock watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    // One counter times the inhibit window and, afterwards, the gap between device clock falls.
    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    ps2tx_state_e state_q, state_d;
    logic [8:0]    shreg_q, shreg_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          nack_q, nack_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          clk_lvl, clk_fall, data_lvl, data_fall_unused;

    ps2_edge_sync u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ps2_clk_in),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_edge_sync u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ps2_data_in),
        .level (data_lvl),
        .fall  (data_fall_unused)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        cnt_d     = cnt_q + 1'b1;
        busy_d    = busy_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            PS2TX_IDLE: begin
                cnt_d = '0;
                if (tx_start) begin
                    shreg_d  = {odd_parity(tx_data), tx_data};
                    nack_d   = 1'b0;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = PS2TX_INHIBIT;
                end
            end
            PS2TX_INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = PS2TX_REQ;
                end
            end
            PS2TX_REQ: begin
                bitcnt_d = '0;
                state_d  = PS2TX_SHIFT;
            end
            PS2TX_SHIFT: begin
                if (clk_fall) begin
                    data_oe_d = (bitcnt_q == 4'd9) ? 1'b0 : ~shreg_q[bitcnt_q];
                    bitcnt_d  = bitcnt_q + 4'd1;
                    state_d   = (bitcnt_q == 4'd9) ? PS2TX_ACK : PS2TX_SHIFT;
                end
            end
            PS2TX_ACK: begin
                if (clk_fall) begin
                    nack_d  = data_lvl;
                    state_d = PS2TX_WAITHI;
                end
            end
            PS2TX_WAITHI: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    busy_d  = 1'b0;
                    state_d = PS2TX_IDLE;
                end
            end
            default: state_d = PS2TX_IDLE;
        endcase
        if (clk_fall && state_q inside {PS2TX_SHIFT, PS2TX_ACK, PS2TX_WAITHI}) cnt_d = '0;
`ifdef PS2_TX_TIMEOUT_EN
        if (state_q inside {PS2TX_SHIFT, PS2TX_ACK, PS2TX_WAITHI} && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            state_d   = PS2TX_IDLE;
        end
`else
        // Without the watchdog a silent device parks the FSM here until rst.
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PS2TX_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench with an open-collector PS/2 device model for ps2_host_tx.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH = 40;
    localparam int TO  = 600;
    localparam int H   = 10;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] bits;
        bit         err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    int         tests = 0;
    int         failed = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference frame as the device sees it: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame(input logic [7:0] d);
        int ones = $countones(d);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) check("err_with_done", 32'(tx_done), 1);
    end

    initial begin
        #800_000;
        $display("FAIL global_timeout: simulation still running");
        $fatal(1);
    end

    task automatic send_start(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_latency", 32'(tx_busy), 1);
        check("clk_oe_latency", 32'(ps2_clk_oe), 1);
    endtask

    task automatic wait_req;
        int n = 0;
        while (ps2_clk_oe && n < INH + 20) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        check("req_data_oe", 32'(ps2_data_oe), 1);
    endtask

    task automatic bfm(input bit ack, output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < 11; i++) begin
            repeat (H) @(negedge clk);
            if (i == 10) dev_data_low = ack;
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (i < 10) bits[i] = ps2_data_in;
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit got, output bit err, output int cyc);
        got = 1'b0;
        err = 1'b0;
        cyc = 0;
        while (!got && cyc < lim) begin
            if (tx_done) begin
                got = 1'b1;
                err = tx_err;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", 32'(got), 1);
        if (got) begin
            @(negedge clk);
            check("done_pulse_width", 32'(tx_done), 0);
            check("busy_after", 32'(tx_busy), 0);
            check("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack, output logic [9:0] bits, output bit err);
        bit got;
        int cyc;
        send_start(d);
        wait_req;
        bfm(ack, bits);
        wait_done(60, got, err, cyc);
    endtask

    initial begin
        vec_t       vecs[6];
        logic [9:0] bits;
        bit         err, got, ack, saw_oe;
        int         cyc, d0;
        logic [7:0] d;

        vecs[0] = '{PS2_CMD_SET_LED, 1'b1, 10'h3ED, 1'b0};
        vecs[1] = '{8'h01,           1'b1, 10'h201, 1'b0};
        vecs[2] = '{8'h00,           1'b1, 10'h300, 1'b0};
        vecs[3] = '{PS2_CMD_RESET,   1'b1, 10'h3FF, 1'b0};
        vecs[4] = '{PS2_CMD_RESET,   1'b0, 10'h3FF, 1'b1};
        vecs[5] = '{PS2_RESP_ACK,    1'b1, 10'h3FA, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_err", 32'(tx_err), 0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            xfer(vecs[i].data, vecs[i].ack, bits, err);
            check($sformatf("vec%0d_bits", i), 32'(bits), 32'(vecs[i].bits));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
        end

        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            xfer(d, ack, bits, err);
            check($sformatf("rand%0d_bits", i), 32'(bits), 32'(frame(d)));
            check($sformatf("rand%0d_err", i), 32'(err), 32'(!ack));
        end

        d0 = done_cnt;
        send_start(8'hA5);
        wait_req;
        fork
            bfm(1'b1, bits);
            begin
                repeat (60) @(negedge clk);
                tx_data  = 8'h5A;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_done(60, got, err, cyc);
        check("busy_ignore_bits", 32'(bits), 32'(frame(8'hA5)));
        saw_oe = 1'b0;
        repeat (2 * INH) begin
            @(negedge clk);
            saw_oe |= ps2_clk_oe | tx_busy;
        end
        check("busy_ignore_no_queue", 32'(saw_oe), 0);
        check("busy_ignore_one_done", done_cnt - d0, 1);

        send_start(8'h2C);
        wait_req;
        repeat (4) begin
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_data_oe", 32'(ps2_data_oe), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        check("midrst_clk_oe", 32'(ps2_clk_oe), 0);
        check("midrst_data_oe", 32'(ps2_data_oe), 0);
        check("midrst_busy", 32'(tx_busy), 0);
        repeat (10) @(negedge clk);
        xfer(8'hED, 1'b1, bits, err);
        check("after_rst_bits", 32'(bits), 32'h3ED);
        check("after_rst_err", 32'(err), 0);

        @(negedge clk);
        rst      = 1'b1;
        tx_data  = 8'h77;
        tx_start = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        tx_start = 1'b0;
        @(negedge clk);
        check("rst_wins_busy", 32'(tx_busy), 0);
        check("rst_wins_clk_oe", 32'(ps2_clk_oe), 0);

        d0 = done_cnt;
        send_start(8'h11);
        wait_req;
`ifdef PS2_TX_TIMEOUT_EN
        wait_done(TO + 20, got, err, cyc);
        check("timeout_cycles", cyc, TO);
        check("timeout_err", 32'(err), 1);
`else
        repeat (3 * TO) @(negedge clk);
        check("silent_busy_held", 32'(tx_busy), 1);
        check("silent_no_done", done_cnt - d0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("silent_rst_busy", 32'(tx_busy), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
